// File: rtl/gcd_result_streamer.sv
// gcd_result_streamer: captures two Bezout coefficients on DONE_PULSE and streams them
// sign-extended as 42 x 64-bit AXI4-Stream beats (A beats 0..20, then B beats 21..41).
//
// Ports:
//   CLK            in   clock, all logic on posedge
//   RESETn         in   asynchronous active-low reset
//   DONE_PULSE     in   one-cycle pulse, BEZOUT_A/BEZOUT_B valid
//   BEZOUT_A       in   VAL_W signed coefficient A
//   BEZOUT_B       in   VAL_W signed coefficient B
//   M_AXIS_TDATA   out  DATA_W stream data
//   M_AXIS_TUSER   out  0 = beat of A, 1 = beat of B
//   M_AXIS_TLAST   out  final beat of the result
//   M_AXIS_TVALID  out  beat valid
//   M_AXIS_TREADY  in   sink ready
//   BUSY           out  result captured and not yet fully handed off
//   OVERRUN        out  sticky, a DONE_PULSE was dropped while streaming
//   OVERRUN_CLR    in   clears OVERRUN (a simultaneous set wins)
module gcd_result_streamer #(
    parameter int DATA_W = 64,
    parameter int VAL_W  = 1284
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              DONE_PULSE,
    input  logic [VAL_W-1:0]  BEZOUT_A,
    input  logic [VAL_W-1:0]  BEZOUT_B,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TUSER,
    output logic              M_AXIS_TLAST,
    output logic              M_AXIS_TVALID,
    input  logic              M_AXIS_TREADY,
    output logic              BUSY,
    output logic              OVERRUN,
    input  logic              OVERRUN_CLR
);
    localparam int         BEATS     = (VAL_W + DATA_W - 1) / DATA_W;
    localparam int         EXT_W     = BEATS * DATA_W;
    localparam logic [5:0] LAST_BEAT = 6'(2 * BEATS - 1);
    localparam logic [5:0] B_FIRST   = 6'(BEATS);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [2*EXT_W-1:0] r_buf;
    logic               r_overrun;

    logic [EXT_W-1:0] w_ext_a;
    logic [EXT_W-1:0] w_ext_b;
    logic             w_hs;
    logic             w_last;
    logic             w_capture;
    logic             w_set_ovr;

    assign w_ext_a   = {{(EXT_W - VAL_W){BEZOUT_A[VAL_W-1]}}, BEZOUT_A};
    assign w_ext_b   = {{(EXT_W - VAL_W){BEZOUT_B[VAL_W-1]}}, BEZOUT_B};
    assign w_hs      = (r_state == STREAM) && M_AXIS_TREADY;
    assign w_last    = (r_cnt == LAST_BEAT);
    // A pulse landing on the final handshake is a back-to-back capture, not an overrun
    assign w_capture = DONE_PULSE && ((r_state == IDLE) || (w_hs && w_last));
    assign w_set_ovr = DONE_PULSE && (r_state == STREAM) && !(w_hs && w_last);

    // The buffer shifts down one beat per handshake, so the current beat is always the
    // bottom word; after the last beat it has drained to zero, keeping TDATA at 0 in IDLE.
    assign M_AXIS_TDATA  = r_buf[DATA_W-1:0];
    assign M_AXIS_TVALID = (r_state == STREAM);
    assign M_AXIS_TUSER  = (r_state == STREAM) && (r_cnt >= B_FIRST);
    assign M_AXIS_TLAST  = (r_state == STREAM) && w_last;
    assign BUSY          = (r_state == STREAM);
    assign OVERRUN       = r_overrun;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_buf     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_buf   <= {w_ext_b, w_ext_a};
                r_cnt   <= '0;
                r_state <= STREAM;
            end else if (w_hs) begin
                r_buf <= r_buf >> DATA_W;
                if (w_last)
                    r_state <= IDLE;
                else
                    r_cnt <= r_cnt + 6'd1;
            end
            r_overrun <= w_set_ovr ? 1'b1 : (OVERRUN_CLR ? 1'b0 : r_overrun);
        end
    end
endmodule
